// File: rtl/regfile_pkg.sv
// Shared defaults, FSM state type and constants for the register-file access controller.
package regfile_pkg;

    localparam int unsigned DEF_NREGS  = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_DATA_W = 32;

    localparam int unsigned X0_ADDR = 0;

    typedef enum logic [2:0] {
        StInit,
        StRun,
        StDbgWr,
        StDbgRd,
        StDbgCap,
        StAck
    } state_e;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Core, debug and register-file signals of the access controller, bundled as one bus.
interface regfile_access_ctrl_if import regfile_pkg::*; #(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);

    logic              core_write;
    logic [ADDR_W-1:0] core_wrAddr;
    logic [DATA_W-1:0] core_wrData;
    logic [ADDR_W-1:0] core_rdAddrA;
    logic [ADDR_W-1:0] core_rdAddrB;
    logic              core_halt;
    logic              core_stall;
    logic              init_done;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    logic              rf_write;
    logic [ADDR_W-1:0] rf_wrAddr;
    logic [DATA_W-1:0] rf_wrData;
    logic [ADDR_W-1:0] rf_rdAddrA;
    logic [ADDR_W-1:0] rf_rdAddrB;
    logic [DATA_W-1:0] rf_rdDataB;

    // Controller view.
    modport slave (
        input  core_write, core_wrAddr, core_wrData, core_rdAddrA, core_rdAddrB, core_halt,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  rf_rdDataB,
        output core_stall, init_done, dbg_ack, dbg_rdata,
        output rf_write, rf_wrAddr, rf_wrData, rf_rdAddrA, rf_rdAddrB
    );

    // Environment view: core, debugger and register file together.
    modport master (
        output core_write, core_wrAddr, core_wrData, core_rdAddrA, core_rdAddrB, core_halt,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output rf_rdDataB,
        input  core_stall, init_done, dbg_ack, dbg_rdata,
        input  rf_write, rf_wrAddr, rf_wrData, rf_rdAddrA, rf_rdAddrB
    );

endinterface

// File: rtl/regfile_scrub_counter.sv
// Post-reset scrub address counter; starts at 1 so x0 is never written, flags completion.
module regfile_scrub_counter import regfile_pkg::*; #(
    parameter int unsigned NREGS  = DEF_NREGS,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o,
    output logic              done_o
);

    // One extra bit so the final increment past NREGS-1 cannot alias back onto x0.
    logic [ADDR_W:0] cnt_q, cnt_d;
    logic            done_q, done_d;

    assign addr_o = cnt_q[ADDR_W-1:0];
    assign last_o = (cnt_q == (ADDR_W+1)'(NREGS - 1));
    assign done_o = done_q;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        if (en_i) begin
            cnt_d = cnt_q + 1'b1;
            if (last_o) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= (ADDR_W+1)'(1);
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file front end: post-reset scrub, core pass-through and debug port arbitration.
module regfile_access_ctrl import regfile_pkg::*; #(
    parameter int unsigned       NREGS      = DEF_NREGS,
    parameter int unsigned       ADDR_W     = DEF_ADDR_W,
    parameter int unsigned       DATA_W     = DEF_DATA_W,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_access_ctrl_if.slave  bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              scrub_en;
    logic [ADDR_W-1:0] scrub_addr;
    logic              scrub_last;
    logic              scrub_done;

    logic              rf_write;
    logic [ADDR_W-1:0] rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;
    logic [ADDR_W-1:0] rf_rd_addr_b;
    logic              core_stall;
    logic              dbg_ack;
    logic              dbg_accept;

    regfile_scrub_counter #(
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_scrub (
        .clk    (clk),
        .reset  (reset),
        .en_i   (scrub_en),
        .addr_o (scrub_addr),
        .last_o (scrub_last),
        .done_o (scrub_done)
    );

    // A pending core writeback would collide with a debug write, so it blocks acceptance.
    assign dbg_accept = bus.dbg_req & bus.core_halt & ~bus.core_write;

    always_comb begin
        state_d      = state_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        rdata_d      = rdata_q;
        scrub_en     = 1'b0;
        rf_write     = bus.core_write;
        rf_wr_addr   = bus.core_wrAddr;
        rf_wr_data   = bus.core_wrData;
        rf_rd_addr_b = bus.core_rdAddrB;
        core_stall   = 1'b1;
        dbg_ack      = 1'b0;

        unique case (state_q)
            StInit: begin
                scrub_en   = 1'b1;
                rf_write   = 1'b1;
                rf_wr_addr = scrub_addr;
                rf_wr_data = INIT_VALUE;
                if (scrub_last) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                core_stall = 1'b0;
                if (dbg_accept) begin
                    lat_addr_d  = bus.dbg_addr;
                    lat_wdata_d = bus.dbg_wdata;
                    state_d     = bus.dbg_we ? StDbgWr : StDbgRd;
                end
            end
            StDbgWr: begin
                // An in-flight core writeback keeps the port; the debug write waits a cycle.
                if (!bus.core_write) begin
                    rf_write   = (lat_addr_q != ADDR_W'(X0_ADDR));
                    rf_wr_addr = lat_addr_q;
                    rf_wr_data = lat_wdata_q;
                    state_d    = StAck;
                end
            end
            StDbgRd: begin
                rf_rd_addr_b = lat_addr_q;
                state_d      = StDbgCap;
            end
            StDbgCap: begin
                rdata_d = bus.rf_rdDataB;
                state_d = StAck;
            end
            StAck: begin
                dbg_ack = 1'b1;
                state_d = StRun;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StInit;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.rf_write   = rf_write;
    assign bus.rf_wrAddr  = rf_wr_addr;
    assign bus.rf_wrData  = rf_wr_data;
    assign bus.rf_rdAddrA = bus.core_rdAddrA;
    assign bus.rf_rdAddrB = rf_rd_addr_b;
    assign bus.core_stall = core_stall;
    assign bus.init_done  = scrub_done;
    assign bus.dbg_ack    = dbg_ack;
    assign bus.dbg_rdata  = rdata_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Randomised bench: behavioural register file plus a transaction-level reference of its contents.
module tb_regfile_access_ctrl;
    import regfile_pkg::*;

    localparam int unsigned NR = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic poison = 1'b0;

    always #5 clk = ~clk;

    regfile_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    regfile_access_ctrl #(
        .NREGS      (NR),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .INIT_VALUE (32'h0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Register file: registered read port B with write forwarding, x0 reads zero.
    logic [DW-1:0] mem [NR];
    always @(posedge clk) begin
        if (poison) begin
            for (int i = 0; i < NR; i++) mem[i] <= $urandom;
        end else if (bus.rf_write && bus.rf_wrAddr != 0) begin
            mem[bus.rf_wrAddr] <= bus.rf_wrData;
        end
        if (bus.rf_rdAddrB == 0) bus.rf_rdDataB <= '0;
        else if (bus.rf_write && bus.rf_wrAddr == bus.rf_rdAddrB) bus.rf_rdDataB <= bus.rf_wrData;
        else bus.rf_rdDataB <= mem[bus.rf_rdAddrB];
    end

    // Expected architectural contents.
    logic [DW-1:0] ref_rf [NR];

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (a != 0) ref_rf[a] = d;
    endfunction

    task automatic drive_point();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.core_write   = 1'b0;
        bus.core_wrAddr  = '0;
        bus.core_wrData  = '0;
        bus.core_rdAddrA = '0;
        bus.core_rdAddrB = '0;
        bus.core_halt    = 1'b0;
        bus.dbg_req      = 1'b0;
        bus.dbg_we       = 1'b0;
        bus.dbg_addr     = '0;
        bus.dbg_wdata    = '0;
    endtask

    // Reset, optionally re-assert reset when the scrub reaches abort_at, then verify the scrub.
    task automatic reset_and_scrub(input int abort_at);
        int  n;
        bit  found;
        idle_inputs();
        reset = 1'b1;
        drive_point();
        poison = 1'b1;
        drive_point();
        poison = 1'b0;
        @(negedge clk);
        check("rst_stall", bus.core_stall, 1);
        check("rst_init_done", bus.init_done, 0);
        check("rst_ack", bus.dbg_ack, 0);
        check("rst_rdata", bus.dbg_rdata, 0);
        drive_point();
        reset = 1'b0;
        if (abort_at > 0) begin
            found = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (bus.rf_wrAddr == AW'(abort_at)) begin
                    found = 1'b1;
                    break;
                end
                drive_point();
            end
            check("abort_seen", found, 1);
            reset = 1'b1;
            #1;
            check("abort_addr", bus.rf_wrAddr, 1);
            check("abort_stall", bus.core_stall, 1);
            drive_point();
            reset = 1'b0;
        end
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.init_done) break;
            check("scrub_we", bus.rf_write, 1);
            check("scrub_addr", bus.rf_wrAddr, n + 1);
            check("scrub_data", bus.rf_wrData, 0);
            check("scrub_stall", bus.core_stall, 1);
            n++;
            drive_point();
        end
        check("scrub_len", n, NR - 1);
        check("run_stall0", bus.core_stall, 0);
        check("run_init_done", bus.init_done, 1);
        for (int i = 0; i < NR; i++) ref_rf[i] = '0;
        drive_point();
    endtask

    // One debug access from acceptance to ack; conflict injects a core write during DBG_WR.
    task automatic dbg_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit conflict, input logic [AW-1:0] ca, input logic [DW-1:0] cd);
        bus.dbg_req      = 1'b1;
        bus.dbg_we       = we;
        bus.dbg_addr     = a;
        bus.dbg_wdata    = d;
        bus.core_halt    = 1'b1;
        bus.core_write   = 1'b0;
        bus.core_rdAddrA = AW'($urandom);
        bus.core_rdAddrB = AW'($urandom);
        @(negedge clk);
        check("acc_stall", bus.core_stall, 0);
        check("acc_rdaddrA", bus.rf_rdAddrA, bus.core_rdAddrA);
        check("acc_rdaddrB", bus.rf_rdAddrB, bus.core_rdAddrB);
        drive_point();
        bus.dbg_we    = ~we;
        bus.dbg_addr  = ~a;
        bus.dbg_wdata = ~d;
        if (we) begin
            if (conflict) begin
                bus.core_write  = 1'b1;
                bus.core_wrAddr = ca;
                bus.core_wrData = cd;
                @(negedge clk);
                check("cw_we", bus.rf_write, 1);
                check("cw_addr", bus.rf_wrAddr, ca);
                check("cw_data", bus.rf_wrData, cd);
                check("cw_stall", bus.core_stall, 1);
                check("cw_ack", bus.dbg_ack, 0);
                ref_write(ca, cd);
                drive_point();
                bus.core_write = 1'b0;
            end
            @(negedge clk);
            check("dw_we", bus.rf_write, a != 0);
            if (a != 0) begin
                check("dw_addr", bus.rf_wrAddr, a);
                check("dw_data", bus.rf_wrData, d);
            end
            check("dw_stall", bus.core_stall, 1);
            check("dw_ack", bus.dbg_ack, 0);
            ref_write(a, d);
            drive_point();
        end else begin
            @(negedge clk);
            check("dr_addrB", bus.rf_rdAddrB, a);
            check("dr_stall", bus.core_stall, 1);
            check("dr_ack", bus.dbg_ack, 0);
            drive_point();
            @(negedge clk);
            check("dc_stall", bus.core_stall, 1);
            check("dc_ack", bus.dbg_ack, 0);
            drive_point();
        end
        @(negedge clk);
        check("ack", bus.dbg_ack, 1);
        check("ack_stall", bus.core_stall, 1);
        if (!we) check("rdata", bus.dbg_rdata, ref_rf[a]);
        drive_point();
        bus.dbg_req = 1'b0;
        @(negedge clk);
        check("post_ack", bus.dbg_ack, 0);
        check("post_stall", bus.core_stall, 0);
        if (!we) check("rdata_hold", bus.dbg_rdata, ref_rf[a]);
        drive_point();
    endtask

    task automatic core_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.core_write  = 1'b1;
        bus.core_wrAddr = a;
        bus.core_wrData = d;
        @(negedge clk);
        check("core_we", bus.rf_write, 1);
        check("core_addr", bus.rf_wrAddr, a);
        check("core_data", bus.rf_wrData, d);
        check("core_stall", bus.core_stall, 0);
        ref_write(a, d);
        drive_point();
        bus.core_write = 1'b0;
    endtask

    // Request held while the core is running, then while it writes back: never accepted.
    task automatic blocked_req(input int cycles);
        bus.dbg_req   = 1'b1;
        bus.dbg_we    = $urandom_range(0, 1);
        bus.dbg_addr  = AW'($urandom);
        bus.core_halt = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            check("blk_halt_stall", bus.core_stall, 0);
            drive_point();
        end
        bus.core_halt = 1'b1;
        core_wr(AW'($urandom), $urandom);
        bus.dbg_req = 1'b0;
        @(negedge clk);
        check("blk_cw_stall", bus.core_stall, 0);
        check("blk_ack", bus.dbg_ack, 0);
        drive_point();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        reset_and_scrub(0);
        reset_and_scrub(12);

        dbg_op(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        dbg_op(1'b0, 5'd5, 32'h0, 1'b0, 5'd0, 32'h0);
        dbg_op(1'b0, 5'd9, 32'h0, 1'b0, 5'd0, 32'h0);
        dbg_op(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0);
        dbg_op(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        dbg_op(1'b1, 5'd7, 32'hA5A5_0007, 1'b1, 5'd3, 32'h0000_0333);
        dbg_op(1'b0, 5'd7, 32'h0, 1'b0, 5'd0, 32'h0);
        dbg_op(1'b0, 5'd3, 32'h0, 1'b0, 5'd0, 32'h0);
        dbg_op(1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0);
        dbg_op(1'b0, 5'd31, 32'h0, 1'b0, 5'd0, 32'h0);
        blocked_req(3);

        for (int it = 0; it < 120; it++) begin
            case ($urandom_range(0, 4))
                0: core_wr(AW'($urandom), $urandom);
                1: dbg_op(1'b1, AW'($urandom), $urandom, 1'b0, 5'd0, 32'h0);
                2: dbg_op(1'b1, AW'($urandom), $urandom, 1'b1, AW'($urandom), $urandom);
                3: dbg_op(1'b0, AW'($urandom), 32'h0, 1'b0, 5'd0, 32'h0);
                default: blocked_req($urandom_range(1, 3));
            endcase
        end

        reset_and_scrub(0);
        dbg_op(1'b0, 5'd5, 32'h0, 1'b0, 5'd0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
